dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_if.sv | 48 ++++
 rtl/dispatch_queue.sv | 114 +++++++++++
 tb/tb_dispatch_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// rtl/dispatch_queue_if.sv - payload types and rename/RS handshake bundle for dispatch_queue
package dispatch_queue_pkg;
  localparam int PHY_REG_NUM = 64;
  localparam int PREG_W      = $clog2(PHY_REG_NUM);
  localparam int WB_WIDTH    = 4;
  localparam int ROB_W       = 6;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] pdest;
    logic [PREG_W-1:0] psrc0;
    logic              psrc0_ready;
    logic [PREG_W-1:0] psrc1;
    logic              psrc1_ready;
  } RsBaseSt;

  typedef struct packed {
    logic [3:0]  fu_op;
    logic [11:0] imm;
  } OptionCodeSt;
endpackage

interface dispatch_queue_if #(
  parameter int BANK_NUM = 2
);
  import dispatch_queue_pkg::*;

  logic [BANK_NUM-1:0]                 rn_valid_i;
  logic                                rn_ready_o;
  RsBaseSt                             rs_base_i     [BANK_NUM];
  OptionCodeSt                         option_code_i [BANK_NUM];
  logic [WB_WIDTH-1:0]                 wb_i;
  logic [WB_WIDTH-1:0][PREG_W-1:0]     wb_pdest_i;
  logic [BANK_NUM-1:0]                 wr_valid_o;
  logic [BANK_NUM-1:0]                 wr_ready_i;
  RsBaseSt                             rs_base_o     [BANK_NUM];
  OptionCodeSt                         option_code_o [BANK_NUM];

  modport master (
    output rn_valid_i, rs_base_i, option_code_i, wb_i, wb_pdest_i, wr_ready_i,
    input  rn_ready_o, wr_valid_o, rs_base_o, option_code_o
  );

  modport slave (
    input  rn_valid_i, rs_base_i, option_code_i, wb_i, wb_pdest_i, wr_ready_i,
    output rn_ready_o, wr_valid_o, rs_base_o, option_code_o
  );
endinterface

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order circular dispatch queue between rename and RS banks with wakeup snooping
// Optional macro DQ_ENQ_WAKEUP_BYPASS_EN: also snoop the writeback bus for entries being enqueued.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int BANK_NUM    = 2
) (
  input  logic          clk,
  input  logic          a_rst_n,
  input  logic          flush_i,
  dispatch_queue_if.slave dq
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] BANK_C  = CNT_W'(BANK_NUM);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, enq_cnt, deq_cnt;
  logic             enq_en;
  logic             run;
  logic [BANK_NUM-1:0] wr_valid;
  logic [PTR_W-1:0] rd_idx [BANK_NUM];
  logic [PTR_W-1:0] wr_idx [BANK_NUM];
  RsBaseSt          enq_base [BANK_NUM];

  RsBaseSt     base_q [QUEUE_DEPTH];
  OptionCodeSt opt_q  [QUEUE_DEPTH];

  function automatic logic wake_hit(
    input logic [PREG_W-1:0]               p,
    input logic [WB_WIDTH-1:0]             wb,
    input logic [WB_WIDTH-1:0][PREG_W-1:0] pdest
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WB_WIDTH; j++) begin
      hit = hit | (wb[j] && (pdest[j] == p));
    end
    return hit;
  endfunction

  // Readiness uses registered occupancy only; a same-cycle dequeue earns no credit.
  assign dq.rn_ready_o = (DEPTH_C - count_q) >= BANK_C;
  assign enq_en        = dq.rn_ready_o && !flush_i;
  assign dq.wr_valid_o = wr_valid;

  always_comb begin
    enq_cnt = '0;
    deq_cnt = '0;
    run     = 1'b1;
    for (int k = 0; k < BANK_NUM; k++) begin
      rd_idx[k]   = head_q + PTR_W'(k);
      wr_idx[k]   = tail_q + PTR_W'(k);
      wr_valid[k] = !flush_i && (count_q > CNT_W'(k));
      // A stalled lane blocks every lane above it to keep dispatch in order.
      run = run && wr_valid[k] && dq.wr_ready_i[k];
      if (run) deq_cnt = deq_cnt + ONE_C;
      if (enq_en && dq.rn_valid_i[k]) enq_cnt = enq_cnt + ONE_C;

      dq.rs_base_o[k]             = base_q[rd_idx[k]];
      dq.rs_base_o[k].psrc0_ready = base_q[rd_idx[k]].psrc0_ready
                                    | wake_hit(base_q[rd_idx[k]].psrc0, dq.wb_i, dq.wb_pdest_i);
      dq.rs_base_o[k].psrc1_ready = base_q[rd_idx[k]].psrc1_ready
                                    | wake_hit(base_q[rd_idx[k]].psrc1, dq.wb_i, dq.wb_pdest_i);
      dq.option_code_o[k]         = opt_q[rd_idx[k]];

      enq_base[k] = dq.rs_base_i[k];
`ifdef DQ_ENQ_WAKEUP_BYPASS_EN
      enq_base[k].psrc0_ready = dq.rs_base_i[k].psrc0_ready
                                | wake_hit(dq.rs_base_i[k].psrc0, dq.wb_i, dq.wb_pdest_i);
      enq_base[k].psrc1_ready = dq.rs_base_i[k].psrc1_ready
                                | wake_hit(dq.rs_base_i[k].psrc1, dq.wb_i, dq.wb_pdest_i);
`endif
    end
    head_d  = head_q + deq_cnt[PTR_W-1:0];
    tail_d  = tail_q + enq_cnt[PTR_W-1:0];
    count_d = count_q + enq_cnt - deq_cnt;
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Stale slots may also be woken; they are never visible while their lane is invalid.
  always_ff @(posedge clk) begin
    for (int e = 0; e < QUEUE_DEPTH; e++) begin
      base_q[e].psrc0_ready <= base_q[e].psrc0_ready
                               | wake_hit(base_q[e].psrc0, dq.wb_i, dq.wb_pdest_i);
      base_q[e].psrc1_ready <= base_q[e].psrc1_ready
                               | wake_hit(base_q[e].psrc1, dq.wb_i, dq.wb_pdest_i);
    end
    for (int k = 0; k < BANK_NUM; k++) begin
      if (enq_en && dq.rn_valid_i[k]) begin
        base_q[wr_idx[k]] <= enq_base[k];
        opt_q[wr_idx[k]]  <= dq.option_code_i[k];
      end
    end
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int BANKS = 2;
`ifdef DQ_ENQ_WAKEUP_BYPASS_EN
  localparam logic BYP_EN = 1'b1;
`else
  localparam logic BYP_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0]  rob;
    logic [5:0]  p0;
    logic        r0;
    logic [5:0]  p1;
    logic        r1;
    logic [11:0] imm;
  } ent_t;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic flush_i = 1'b0;
  always #5 clk = ~clk;

  dispatch_queue_if #(.BANK_NUM(BANKS)) dq_if ();

  dispatch_queue #(.QUEUE_DEPTH(DEPTH), .BANK_NUM(BANKS)) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .flush_i (flush_i),
    .dq      (dq_if)
  );

  ent_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] next_rob = '0;
  logic [5:0] lane_p0 [BANKS];
  logic [5:0] lane_p1 [BANKS];
  logic       lane_r0 [BANKS];
  logic       lane_r1 [BANKS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic tb_wake(input logic [5:0] p);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WB_WIDTH; j++)
      if (dq_if.wb_i[j] && dq_if.wb_pdest_i[j] == p) hit = 1'b1;
    return hit;
  endfunction

  // One cycle: drive at edge+1, check at edge+2, update model, advance to next edge+1.
  task automatic step(input logic [1:0] rv, input logic [1:0] rdy, input logic fl);
    logic exp_ready, run;
    logic exp_v [BANKS];
    int   n;
    ent_t e;
    for (int k = 0; k < BANKS; k++) begin
      dq_if.rs_base_i[k].rob_idx     = next_rob + 6'(k);
      dq_if.rs_base_i[k].pdest       = 6'($urandom_range(0, 63));
      dq_if.rs_base_i[k].psrc0       = lane_p0[k];
      dq_if.rs_base_i[k].psrc0_ready = lane_r0[k];
      dq_if.rs_base_i[k].psrc1       = lane_p1[k];
      dq_if.rs_base_i[k].psrc1_ready = lane_r1[k];
      dq_if.option_code_i[k].fu_op   = 4'(k);
      dq_if.option_code_i[k].imm     = 12'($urandom_range(0, 4095));
    end
    dq_if.rn_valid_i = rv;
    dq_if.wr_ready_i = rdy;
    flush_i = fl;
    #1;
    exp_ready = (DEPTH - sb.size()) >= BANKS;
    check("rn_ready", 32'(dq_if.rn_ready_o), 32'(exp_ready));
    check("count", 32'(dut.count_q), 32'(sb.size()));
    for (int k = 0; k < BANKS; k++) begin
      exp_v[k] = !fl && (sb.size() > k);
      check($sformatf("wr_valid%0d", k), 32'(dq_if.wr_valid_o[k]), 32'(exp_v[k]));
      if (exp_v[k]) begin
        check($sformatf("rob%0d", k), 32'(dq_if.rs_base_o[k].rob_idx), 32'(sb[k].rob));
        check($sformatf("r0_%0d", k), 32'(dq_if.rs_base_o[k].psrc0_ready),
              32'(sb[k].r0 | tb_wake(sb[k].p0)));
        check($sformatf("r1_%0d", k), 32'(dq_if.rs_base_o[k].psrc1_ready),
              32'(sb[k].r1 | tb_wake(sb[k].p1)));
        check($sformatf("imm%0d", k), 32'(dq_if.option_code_o[k].imm), 32'(sb[k].imm));
      end
    end
    n = 0;
    run = 1'b1;
    for (int k = 0; k < BANKS; k++) begin
      run = run && exp_v[k] && rdy[k];
      if (run) n++;
    end
    if (fl) begin
      sb.delete();
    end else begin
      repeat (n) void'(sb.pop_front());
      foreach (sb[i]) begin
        sb[i].r0 = sb[i].r0 | tb_wake(sb[i].p0);
        sb[i].r1 = sb[i].r1 | tb_wake(sb[i].p1);
      end
      if (exp_ready) begin
        for (int k = 0; k < BANKS; k++) begin
          if (rv[k]) begin
            e.rob = dq_if.rs_base_i[k].rob_idx;
            e.p0  = lane_p0[k];
            e.p1  = lane_p1[k];
            e.r0  = lane_r0[k] | (BYP_EN & tb_wake(lane_p0[k]));
            e.r1  = lane_r1[k] | (BYP_EN & tb_wake(lane_p1[k]));
            e.imm = dq_if.option_code_i[k].imm;
            sb.push_back(e);
          end
        end
      end
    end
    next_rob = next_rob + 6'(BANKS);
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [5:0] p0, input logic [5:0] p1);
    for (int k = 0; k < BANKS; k++) begin
      lane_p0[k] = p0 + 6'(k);
      lane_p1[k] = p1 + 6'(k);
      lane_r0[k] = 1'b0;
      lane_r1[k] = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] rv;
    dq_if.rn_valid_i = '0;
    dq_if.wr_ready_i = '0;
    dq_if.wb_i = '0;
    dq_if.wb_pdest_i = '0;
    set_lanes(6'd30, 6'd40);
    #1;
    check("rst_wr_valid", 32'(dq_if.wr_valid_o), 32'h0);
    check("rst_rn_ready", 32'(dq_if.rn_ready_o), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;

    next_rob = 6'd4;
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    step(2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);

    step(2'b00, 2'b00, 1'b1);
    repeat (4) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    check("tail_wrap", 32'(dut.tail_q), 32'd2);
    repeat (5) step(2'b00, 2'b11, 1'b0);

    lane_p0[0] = 6'd17;
    step(2'b01, 2'b00, 1'b0);
    dq_if.wb_i[0] = 1'b1;
    dq_if.wb_pdest_i[0] = 6'd17;
    #1;
    check("wake_patch", 32'(dq_if.rs_base_o[0].psrc0_ready), 32'h1);
    step(2'b00, 2'b00, 1'b0);
    dq_if.wb_i = '0;
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);

    set_lanes(6'd30, 6'd40);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b11, 1'b1);
    step(2'b00, 2'b00, 1'b0);

    lane_p1[0] = 6'd9;
    dq_if.wb_i[1] = 1'b1;
    dq_if.wb_pdest_i[1] = 6'd9;
    step(2'b01, 2'b00, 1'b0);
    dq_if.wb_i = '0;
    #1;
    check("enq_bypass", 32'(dq_if.rs_base_o[0].psrc1_ready), 32'(BYP_EN));
    step(2'b00, 2'b01, 1'b0);

    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < BANKS; k++) begin
        lane_p0[k] = 6'($urandom_range(0, 7));
        lane_p1[k] = 6'($urandom_range(0, 7));
        lane_r0[k] = 1'($urandom_range(0, 1));
        lane_r1[k] = 1'($urandom_range(0, 1));
      end
      dq_if.wb_i = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int j = 0; j < WB_WIDTH; j++) dq_if.wb_pdest_i[j] = 6'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: rv = 2'b00;
        1: rv = 2'b01;
        default: rv = 2'b11;
      endcase
      step(rv, 2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
    end
    dq_if.wb_i = '0;

    set_lanes(6'd30, 6'd40);
    step(2'b00, 2'b00, 1'b1);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    a_rst_n = 1'b0;
    #1;
    check("midrst_wr_valid", 32'(dq_if.wr_valid_o), 32'h0);
    check("midrst_rn_ready", 32'(dq_if.rn_ready_o), 32'h1);
    check("midrst_count", 32'(dut.count_q), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    step(2'b00, 2'b11, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
